vga_port_writer: RTL

//  Port-write initiator for the VGA display controller's port-mapped register file. On request,

---
 rtl/vga_port_writer.sv | 329 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_port_writer.sv
// rtl/vga_port_writer.sv - framed port-write initiator for the VGA display register file
//
// Purpose:
//   On a frame request, snapshots the BCD date/time/timer values and status bits and
//   writes them to the display controller as one framed burst:
//     0x19 <- 0x00 (freeze), ports 0x04..0x18, ports 0x1a..0x1f, 0x19 <- HS_COMMIT.
//   A timer-end event produces a single 0x20 <- 0x01 write, appended to a running
//   frame or issued on its own when idle.
//
// Parameters:
//   STROBE_GAP  idle cycles between consecutive strobes (0..7, 0 = back-to-back)
//   HS_COMMIT   data written to port 0x19 to close a frame
//
// Ports:
//   reloj_nexys    in   system clock
//   reset_total    in   asynchronous active-high reset
//   start          in   frame request
//   fin_crono      in   timer-end pulse
//   agno,mes,dia   in   BCD date {tens,units}
//   hora,min,seg   in   BCD time
//   hc,mc,sc       in   BCD programmed timer
//   hr,mr,sr       in   BCD running timer
//   am_pm,formato  in   status bits
//   cursor         in   cursor position
//   prog           in   programming-target key code
//   write_strobe   out  1-cycle write qualifier
//   id_port        out  port address (held between strobes)
//   dato           out  write data (held between strobes)
//   busy           out  frame or flag write in progress
//   done           out  1-cycle pulse after the last strobe

module vga_port_writer #(
  parameter int         STROBE_GAP = 1,
  parameter logic [7:0] HS_COMMIT  = 8'hFF
) (
  input  logic       reloj_nexys,
  input  logic       reset_total,
  input  logic       start,
  input  logic       fin_crono,
  input  logic [7:0] agno,
  input  logic [7:0] mes,
  input  logic [7:0] dia,
  input  logic [7:0] hora,
  input  logic [7:0] min,
  input  logic [7:0] seg,
  input  logic [7:0] hc,
  input  logic [7:0] mc,
  input  logic [7:0] sc,
  input  logic [7:0] hr,
  input  logic [7:0] mr,
  input  logic [7:0] sr,
  input  logic       am_pm,
  input  logic       formato,
  input  logic [2:0] cursor,
  input  logic [7:0] prog,
  output logic       write_strobe,
  output logic [7:0] id_port,
  output logic [7:0] dato,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    GAP,
    FLAG,
    DONE
  } state_t;

  localparam logic [4:0] LAST_IDX  = 5'd28;
  localparam logic [2:0] GAP_LOAD  = (STROBE_GAP > 0) ? 3'(STROBE_GAP - 1) : 3'd0;
  localparam logic [7:0] PORT_HS   = 8'h19;
  localparam logic [7:0] PORT_FLAG = 8'h20;
  localparam logic [7:0] FLAG_DATA = 8'h01;

  logic reset_interno;
  assign reset_interno = reset_total;

  state_t     state, nxt_state;
  logic [4:0] idx, nxt_idx;
  logic [2:0] gap_cnt, nxt_gap;
  logic       start_pend, nxt_start_pend;
  logic       flag_pend, nxt_flag_pend;
  logic       nxt_strobe, nxt_busy, nxt_done;
  logic [7:0] nxt_id, nxt_dato;
  logic       capture;

  // Snapshot of every input carried by a frame, taken at the capture edge so
  // later input changes never tear a frame.
  logic [7:0] snap_agno, snap_mes, snap_dia, snap_hora, snap_min, snap_seg;
  logic [7:0] snap_hc, snap_mc, snap_sc, snap_hr, snap_mr, snap_sr;
  logic       snap_am_pm, snap_formato;
  logic [2:0] snap_cursor;
  logic [7:0] snap_prog;

  // Table entry for the strobe that follows the current one.
  logic [4:0] tbl_idx;
  logic [7:0] tbl_port;
  logic [7:0] tbl_data;

  assign tbl_idx = idx + 5'd1;

  function automatic logic [7:0] port_of(input logic [4:0] i);
    logic [7:0] p;
    if (i == 5'd0 || i == LAST_IDX) begin
      p = PORT_HS;
    end else if (i <= 5'd21) begin
      p = {3'b000, i} + 8'd3;   // 0x04..0x18
    end else begin
      p = {3'b000, i} + 8'd4;   // skip 0x19: 0x1a..0x1f
    end
    return p;
  endfunction

  function automatic logic [7:0] hi_nib(input logic [7:0] v);
    return {4'h0, v[7:4]};
  endfunction

  function automatic logic [7:0] lo_nib(input logic [7:0] v);
    return {4'h0, v[3:0]};
  endfunction

  always_comb begin : table_lookup
    tbl_port = port_of(tbl_idx);
    tbl_data = 8'h00;
    case (tbl_port)
      8'h04: tbl_data = hi_nib(snap_agno);
      8'h05: tbl_data = lo_nib(snap_agno);
      8'h06: tbl_data = hi_nib(snap_mes);
      8'h07: tbl_data = lo_nib(snap_mes);
      8'h08: tbl_data = hi_nib(snap_dia);
      8'h09: tbl_data = lo_nib(snap_dia);
      8'h0a: tbl_data = hi_nib(snap_hora);
      8'h0b: tbl_data = lo_nib(snap_hora);
      8'h0c: tbl_data = hi_nib(snap_min);
      8'h0d: tbl_data = lo_nib(snap_min);
      8'h0e: tbl_data = hi_nib(snap_seg);
      8'h0f: tbl_data = lo_nib(snap_seg);
      8'h10: tbl_data = hi_nib(snap_hr);
      8'h11: tbl_data = lo_nib(snap_hr);
      8'h12: tbl_data = hi_nib(snap_mr);
      8'h13: tbl_data = lo_nib(snap_mr);
      8'h14: tbl_data = hi_nib(snap_sr);
      8'h15: tbl_data = lo_nib(snap_sr);
      8'h16: tbl_data = {3'b000, snap_am_pm, 3'b000, snap_formato};
      8'h17: tbl_data = {5'b00000, snap_cursor};
      8'h18: tbl_data = snap_prog;
      8'h1a: tbl_data = hi_nib(snap_hc);
      8'h1b: tbl_data = lo_nib(snap_hc);
      8'h1c: tbl_data = hi_nib(snap_mc);
      8'h1d: tbl_data = lo_nib(snap_mc);
      8'h1e: tbl_data = hi_nib(snap_sc);
      8'h1f: tbl_data = lo_nib(snap_sc);
      8'h19: tbl_data = (tbl_idx == LAST_IDX) ? HS_COMMIT : 8'h00;
      default: tbl_data = 8'h00;
    endcase
  end

  // Next-state and next-output logic. Outputs are registered, so every branch
  // describes what the pins show in the following cycle.
  always_comb begin : fsm_next
    nxt_state      = state;
    nxt_idx        = idx;
    nxt_gap        = gap_cnt;
    nxt_strobe     = 1'b0;
    nxt_id         = id_port;
    nxt_dato       = dato;
    nxt_busy       = busy;
    nxt_done       = 1'b0;
    nxt_start_pend = start_pend | start;
    nxt_flag_pend  = flag_pend | fin_crono;
    capture        = 1'b0;

    case (state)
      IDLE: begin
        if (start || start_pend) begin
          // Frame wins over a simultaneous flag; the flag stays pending and
          // is appended after the commit write.
          capture        = 1'b1;
          nxt_start_pend = 1'b0;
          nxt_state      = WRITE;
          nxt_idx        = 5'd0;
          nxt_strobe     = 1'b1;
          nxt_id         = PORT_HS;
          nxt_dato       = 8'h00;
          nxt_busy       = 1'b1;
        end else if (flag_pend || fin_crono) begin
          nxt_flag_pend = 1'b0;
          nxt_state     = FLAG;
          nxt_strobe    = 1'b1;
          nxt_id        = PORT_FLAG;
          nxt_dato      = FLAG_DATA;
          nxt_busy      = 1'b1;
        end
      end

      WRITE: begin
        if (idx == LAST_IDX) begin
          if (flag_pend || fin_crono) begin
            if (STROBE_GAP == 0) begin
              nxt_flag_pend = 1'b0;
              nxt_state     = FLAG;
              nxt_strobe    = 1'b1;
              nxt_id        = PORT_FLAG;
              nxt_dato      = FLAG_DATA;
            end else begin
              nxt_state = GAP;
              nxt_gap   = GAP_LOAD;
            end
          end else begin
            nxt_state = DONE;
            nxt_done  = 1'b1;
            nxt_busy  = 1'b0;
          end
        end else if (STROBE_GAP == 0) begin
          nxt_idx    = tbl_idx;
          nxt_strobe = 1'b1;
          nxt_id     = tbl_port;
          nxt_dato   = tbl_data;
        end else begin
          nxt_state = GAP;
          nxt_gap   = GAP_LOAD;
        end
      end

      GAP: begin
        if (gap_cnt == 3'd0) begin
          if (idx == LAST_IDX) begin
            // Only reached from the last frame strobe when a flag is pending.
            nxt_flag_pend = 1'b0;
            nxt_state     = FLAG;
            nxt_strobe    = 1'b1;
            nxt_id        = PORT_FLAG;
            nxt_dato      = FLAG_DATA;
          end else begin
            nxt_state  = WRITE;
            nxt_idx    = tbl_idx;
            nxt_strobe = 1'b1;
            nxt_id     = tbl_port;
            nxt_dato   = tbl_data;
          end
        end else begin
          nxt_gap = gap_cnt - 3'd1;
        end
      end

      FLAG: begin
        nxt_state = DONE;
        nxt_done  = 1'b1;
        nxt_busy  = 1'b0;
      end

      DONE: begin
        nxt_state = IDLE;
      end

      default: begin
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge reloj_nexys or posedge reset_interno) begin : fsm_reg
    if (reset_interno) begin
      state        <= IDLE;
      idx          <= 5'd0;
      gap_cnt      <= 3'd0;
      start_pend   <= 1'b0;
      flag_pend    <= 1'b0;
      write_strobe <= 1'b0;
      id_port      <= 8'h00;
      dato         <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= nxt_state;
      idx          <= nxt_idx;
      gap_cnt      <= nxt_gap;
      start_pend   <= nxt_start_pend;
      flag_pend    <= nxt_flag_pend;
      write_strobe <= nxt_strobe;
      id_port      <= nxt_id;
      dato         <= nxt_dato;
      busy         <= nxt_busy;
      done         <= nxt_done;
    end
  end

  always_ff @(posedge reloj_nexys or posedge reset_interno) begin : snapshot_reg
    if (reset_interno) begin
      snap_agno    <= 8'h00;
      snap_mes     <= 8'h00;
      snap_dia     <= 8'h00;
      snap_hora    <= 8'h00;
      snap_min     <= 8'h00;
      snap_seg     <= 8'h00;
      snap_hc      <= 8'h00;
      snap_mc      <= 8'h00;
      snap_sc      <= 8'h00;
      snap_hr      <= 8'h00;
      snap_mr      <= 8'h00;
      snap_sr      <= 8'h00;
      snap_am_pm   <= 1'b0;
      snap_formato <= 1'b0;
      snap_cursor  <= 3'd0;
      snap_prog    <= 8'h00;
    end else if (capture) begin
      snap_agno    <= agno;
      snap_mes     <= mes;
      snap_dia     <= dia;
      snap_hora    <= hora;
      snap_min     <= min;
      snap_seg     <= seg;
      snap_hc      <= hc;
      snap_mc      <= mc;
      snap_sc      <= sc;
      snap_hr      <= hr;
      snap_mr      <= mr;
      snap_sr      <= sr;
      snap_am_pm   <= am_pm;
      snap_formato <= formato;
      snap_cursor  <= cursor;
      snap_prog    <= prog;
    end
  end

endmodule
